hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
Pipeline hazard controller for the 5-stage pipelined processor. It drives the select lines of the EX-stage operand forwarding muxes and sequences the pipeline-register enables, bubbles and flushes. It handles load-use stalls, taken-branch flushes and a multi-cycle multiply/divide occupancy of EX. It sits beside the datapath and is the only owner of PC_Write, IF/ID write/flush and the ID/EX bubble control.

Parameters:
REG_ADDR_W, 5, register-file address width
MD_LATENCY, 4, total EX cycles occupied by a multiply/divide (range 2..15)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
ID_Rs, ID_Rt  in  REG_ADDR_W  source registers of the instruction in ID
ID_Uses_Rt  in  1  ID instruction reads Rt
ID_MD_Start  in  1  ID instruction is a multiply/divide
EX_Rs, EX_Rt  in  REG_ADDR_W  source registers of the instruction in EX
EX_Rd  in  REG_ADDR_W  destination register in EX
EX_MemRead  in  1  EX instruction is a load
EX_Branch_Taken  in  1  branch resolved taken in EX
MEM_Rd, WB_Rd  in  REG_ADDR_W  destination registers in MEM and WB
MEM_RegWrite, WB_RegWrite  in  1  register-write enables in MEM and WB
Fwd_A_Sel, Fwd_B_Sel  out  2  operand mux selects: 00 regfile, 01 WB result, 10 MEM result
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  zero the IF/ID register
ID_EX_Bubble  out  1  load a NOP into ID/EX
EX_Hold  out  1  freeze ID/EX and the EX-stage multiply/divide
MD_Busy  out  1  multiply/divide in progress
Stall_Count  out  CNT_W  cycles in which PC_Write was 0, saturating

Behaviour:
- Clock and reset: single clock Clk. Reset is asynchronous and active-high. Reset forces state RUN, md_cnt=0 and Stall_Count=0.
- Outputs while Reset=1:
  - PC_Write=0, IF_ID_Write=0
  - IF_ID_Flush=1, ID_EX_Bubble=1
  - EX_Hold=0, MD_Busy=0, Fwd selects 00
- Forwarding (combinational, every state):
  - Fwd_A_Sel=10 if MEM_RegWrite and MEM_Rd!=0 and MEM_Rd==EX_Rs.
  - Otherwise 01 if WB_RegWrite and WB_Rd!=0 and WB_Rd==EX_Rs.
  - Otherwise 00.
  - Fwd_B_Sel follows the same rule using EX_Rt. MEM has priority over WB.
- Hazard terms:
  - load_use = EX_MemRead and EX_Rd!=0 and (EX_Rd==ID_Rs or (ID_Uses_Rt and EX_Rd==ID_Rt)).
- States: RUN, MD_WAIT.
- RUN, priority order (combinational outputs; default PC_Write=1, IF_ID_Write=1, all others 0):
  1. EX_Branch_Taken: IF_ID_Flush=1, ID_EX_Bubble=1; load_use and ID_MD_Start are ignored; stay RUN.
  2. load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; stay RUN. A single cycle suffices because the load then advances to MEM.
  3. ID_MD_Start: normal advance this cycle; next state MD_WAIT with md_cnt=MD_LATENCY-1.
- MD_WAIT:
  - Outputs: PC_Write=0, IF_ID_Write=0, EX_Hold=1, MD_Busy=1, ID_EX_Bubble=0.
  - md_cnt decrements each cycle.
  - When md_cnt==1, the next state is RUN with md_cnt=0. This gives MD_LATENCY-1 hold cycles after the issue cycle, for MD_LATENCY total EX cycles.
  - EX_Branch_Taken is not possible in MD_WAIT. If it is asserted anyway, it is ignored.
- Stall_Count increments on every clock edge where Reset=0 and PC_Write=0. It holds at 2^CNT_W-1.
- Reset mid-MD_WAIT aborts immediately to RUN. No partial state is retained.

Test Plan:
- Reset release, no hazards, stream of independent ops -> PC_Write=1, IF_ID_Write=1, Fwd selects 00, Stall_Count=0.
- Forwarding:
  - MEM_Rd=WB_Rd=EX_Rs=5, both RegWrite=1 -> Fwd_A_Sel=10.
  - Same registers, MEM_RegWrite=0 -> 01.
  - Rd=0 with both enables set -> 00.
- Load-use: EX_MemRead=1, EX_Rd=3, ID_Rt=3, ID_Uses_Rt=1 -> exactly one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; Stall_Count=1 afterwards.
- Branch priority: EX_Branch_Taken=1 coincident with load_use=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; no stall counted.
- Multiply/divide, MD_LATENCY=4:
  - ID_MD_Start=1 for one cycle -> next 3 cycles MD_Busy=1, EX_Hold=1, PC_Write=0, then RUN; Stall_Count=3.
  - Reset asserted during cycle 2 -> MD_Busy=0 immediately.
- Saturation: CNT_W=4, hold load_use for 20 stall cycles -> Stall_Count stops at 15.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: EX operand-forward selects, PC / IF/ID / ID/EX sequencing.
// Latency: forward selects and RUN-state controls are combinational; mul/div holds EX for MD_LATENCY-1 cycles after issue.
// Backpressure: load-use stalls fetch/decode one cycle; mul/div freezes PC, IF/ID and EX until it completes.
//
// Ports:
//   Clk, Reset                  clock (rising edge), asynchronous active-high reset
//   ID_Rs/ID_Rt/ID_Uses_Rt      source operands of the instruction in ID
//   ID_MD_Start                 ID instruction is a multiply/divide
//   EX_Rs/EX_Rt/EX_Rd           operands and destination of the instruction in EX
//   EX_MemRead/EX_Branch_Taken  EX instruction is a load / branch resolved taken
//   MEM_Rd/WB_Rd, *_RegWrite    pending writebacks used for forwarding
//   Fwd_A_Sel/Fwd_B_Sel         00 regfile, 01 WB result, 10 MEM result
//   PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MD_Busy
//   Stall_Count                 saturating count of cycles with PC_Write=0
module hazard_sequencer #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_Uses_Rt,
  input  logic                  ID_MD_Start,
  input  logic [REG_ADDR_W-1:0] EX_Rs,
  input  logic [REG_ADDR_W-1:0] EX_Rt,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  EX_MemRead,
  input  logic                  EX_Branch_Taken,
  input  logic [REG_ADDR_W-1:0] MEM_Rd,
  input  logic [REG_ADDR_W-1:0] WB_Rd,
  input  logic                  MEM_RegWrite,
  input  logic                  WB_RegWrite,
  output logic [1:0]            Fwd_A_Sel,
  output logic [1:0]            Fwd_B_Sel,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Bubble,
  output logic                  EX_Hold,
  output logic                  MD_Busy,
  output logic [CNT_W-1:0]      Stall_Count
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  state_t           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             load_use;
  logic [1:0]       fwd_a, fwd_b;

  // MEM holds the younger result, so it wins over WB; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input logic                  mem_we,
                                         input logic [REG_ADDR_W-1:0] mem_rd,
                                         input logic                  wb_we,
                                         input logic [REG_ADDR_W-1:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(EX_Rs, MEM_RegWrite, MEM_Rd, WB_RegWrite, WB_Rd);
  assign fwd_b = fwd_sel(EX_Rt, MEM_RegWrite, MEM_Rd, WB_RegWrite, WB_Rd);

  assign load_use = EX_MemRead && (EX_Rd != '0) &&
                    ((EX_Rd == ID_Rs) || (ID_Uses_Rt && (EX_Rd == ID_Rt)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    Fwd_A_Sel    = fwd_a;
    Fwd_B_Sel    = fwd_b;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_Hold      = 1'b0;
    MD_Busy      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (EX_Branch_Taken) begin
          // Wrong-path instructions in IF and ID are squashed; the branch
          // outranks any hazard raised by the instruction it is killing.
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
        end else if (load_use) begin
          // One bubble is enough: next cycle the load is in MEM and forwards.
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end else if (ID_MD_Start) begin
          // The issue cycle advances normally and counts as the first EX cycle.
          state_d  = ST_MD_WAIT;
          md_cnt_d = MD_LOAD;
        end
      end
      ST_MD_WAIT: begin
        // A taken branch cannot be resolved while EX is frozen; ignore it.
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        EX_Hold     = 1'b1;
        MD_Busy     = 1'b1;
        if (md_cnt_q == 4'd1) begin
          state_d  = ST_RUN;
          md_cnt_d = 4'd0;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        md_cnt_d = 4'd0;
      end
    endcase

    // Reset keeps the pipeline quiescent: nothing fetched, IF/ID and ID/EX emptied.
    if (Reset) begin
      Fwd_A_Sel    = 2'b00;
      Fwd_B_Sel    = 2'b00;
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      EX_Hold      = 1'b0;
      MD_Busy      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with MD_LATENCY=4 and a 4-bit stall counter.
// Latency: one directed step per clock; outputs sampled on the falling edge.
// Backpressure: none; every step is fixed-length so the run always terminates.
module tb_hazard_sequencer;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          Clk;
  logic          Reset;
  logic [AW-1:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rd, MEM_Rd, WB_Rd;
  logic          ID_Uses_Rt, ID_MD_Start, EX_MemRead, EX_Branch_Taken;
  logic          MEM_RegWrite, WB_RegWrite;
  logic [1:0]    Fwd_A_Sel, Fwd_B_Sel;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MD_Busy;
  logic [CW-1:0] Stall_Count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       pcw, ifw, flush, bub, hold, busy;
    logic [1:0] fa, fb;
    logic [3:0] stall;
  } exp_t;

  exp_t sb[$];

  hazard_sequencer #(.REG_ADDR_W(AW), .MD_LATENCY(4), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Uses_Rt(ID_Uses_Rt), .ID_MD_Start(ID_MD_Start),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
    .EX_Branch_Taken(EX_Branch_Taken),
    .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .Fwd_A_Sel(Fwd_A_Sel), .Fwd_B_Sel(Fwd_B_Sel),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .EX_Hold(EX_Hold), .MD_Busy(MD_Busy),
    .Stall_Count(Stall_Count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Push the expectation for the inputs just driven, then pop and compare
  // against the DUT on the falling edge, then advance to just after the next rise.
  task automatic step(input string tag, input logic pcw, input logic ifw,
                      input logic flush, input logic bub, input logic hold,
                      input logic busy, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] stall);
    exp_t e;
    exp_t got;
    e.tag = tag; e.pcw = pcw; e.ifw = ifw; e.flush = flush; e.bub = bub;
    e.hold = hold; e.busy = busy; e.fa = fa; e.fb = fb; e.stall = stall;
    sb.push_back(e);
    @(negedge Clk);
    got = sb.pop_front();
    chk(got.tag, "PC_Write",     16'(PC_Write),     16'(got.pcw));
    chk(got.tag, "IF_ID_Write",  16'(IF_ID_Write),  16'(got.ifw));
    chk(got.tag, "IF_ID_Flush",  16'(IF_ID_Flush),  16'(got.flush));
    chk(got.tag, "ID_EX_Bubble", 16'(ID_EX_Bubble), 16'(got.bub));
    chk(got.tag, "EX_Hold",      16'(EX_Hold),      16'(got.hold));
    chk(got.tag, "MD_Busy",      16'(MD_Busy),      16'(got.busy));
    chk(got.tag, "Fwd_A_Sel",    16'(Fwd_A_Sel),    16'(got.fa));
    chk(got.tag, "Fwd_B_Sel",    16'(Fwd_B_Sel),    16'(got.fb));
    chk(got.tag, "Stall_Count",  16'(Stall_Count),  16'(got.stall));
    @(posedge Clk);
    #1;
  endtask

  task automatic run_step(input string tag, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [3:0] stall);
    step(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb, stall);
  endtask

  task automatic reset_step(input string tag);
    step(tag, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0);
  endtask

  task automatic md_step(input string tag, input logic [3:0] stall);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, stall);
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_Uses_Rt = 1'b1; ID_MD_Start = 1'b0;
    EX_Rs = 5'd10; EX_Rt = 5'd11; EX_Rd = 5'd12; EX_MemRead = 1'b0;
    EX_Branch_Taken = 1'b0;
    MEM_Rd = 5'd20; WB_Rd = 5'd21; MEM_RegWrite = 1'b1; WB_RegWrite = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    idle_inputs();
    #2 Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Reset forces fetch off, flushes, and zeroes forwarding even with a live match.
    MEM_Rd = 5'd10;
    reset_step("reset");
    idle_inputs();

    Reset = 1'b0;
    run_step("run0", 2'b00, 2'b00, 4'd0);
    run_step("run1", 2'b00, 2'b00, 4'd0);
    run_step("run2", 2'b00, 2'b00, 4'd0);

    // Forwarding priority and r0 exclusion.
    EX_Rs = 5'd5; EX_Rt = 5'd7; MEM_Rd = 5'd5; WB_Rd = 5'd5;
    run_step("fwd_mem_a", 2'b10, 2'b00, 4'd0);
    MEM_RegWrite = 1'b0;
    run_step("fwd_wb_a", 2'b01, 2'b00, 4'd0);
    MEM_RegWrite = 1'b1; MEM_Rd = 5'd7; WB_Rd = 5'd7;
    run_step("fwd_mem_b", 2'b00, 2'b10, 4'd0);
    MEM_Rd = 5'd5;
    run_step("fwd_split", 2'b10, 2'b01, 4'd0);
    EX_Rs = 5'd0; EX_Rt = 5'd0; MEM_Rd = 5'd0; WB_Rd = 5'd0;
    run_step("fwd_r0", 2'b00, 2'b00, 4'd0);
    idle_inputs();

    // Load-use through Rt: exactly one stall cycle.
    EX_MemRead = 1'b1; EX_Rd = 5'd3; ID_Rt = 5'd3; ID_Uses_Rt = 1'b1;
    step("load_use", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0);
    idle_inputs();
    run_step("after_lu", 2'b00, 2'b00, 4'd1);

    // Rt match not counted when the instruction does not read Rt; r0 load is harmless.
    EX_MemRead = 1'b1; EX_Rd = 5'd3; ID_Rt = 5'd3; ID_Uses_Rt = 1'b0;
    run_step("lu_no_rt", 2'b00, 2'b00, 4'd1);
    EX_Rd = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_Uses_Rt = 1'b1;
    run_step("lu_r0", 2'b00, 2'b00, 4'd1);
    idle_inputs();

    // Taken branch outranks a coincident load-use; no stall counted.
    EX_MemRead = 1'b1; EX_Rd = 5'd4; ID_Rs = 5'd4; EX_Branch_Taken = 1'b1;
    step("branch_lu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'd1);
    idle_inputs();
    run_step("after_br", 2'b00, 2'b00, 4'd1);

    // Multiply/divide: issue cycle advances, then three hold cycles.
    ID_MD_Start = 1'b1;
    run_step("md_issue", 2'b00, 2'b00, 4'd1);
    ID_MD_Start = 1'b0;
    md_step("md_w1", 4'd1);
    EX_Branch_Taken = 1'b1;
    md_step("md_w2_br", 4'd2);
    EX_Branch_Taken = 1'b0; EX_Rs = 5'd20;
    step("md_w3_fwd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 4'd3);
    idle_inputs();
    run_step("md_done", 2'b00, 2'b00, 4'd4);

    // Reset during the second hold cycle aborts the operation at once.
    ID_MD_Start = 1'b1;
    run_step("md2_issue", 2'b00, 2'b00, 4'd4);
    ID_MD_Start = 1'b0;
    md_step("md2_w1", 4'd4);
    Reset = 1'b1;
    reset_step("md2_reset");
    Reset = 1'b0;
    run_step("md2_post0", 2'b00, 2'b00, 4'd0);
    run_step("md2_post1", 2'b00, 2'b00, 4'd0);

    // Saturation: 20 load-use stall cycles into a 4-bit counter.
    EX_MemRead = 1'b1; EX_Rd = 5'd6; ID_Rs = 5'd6;
    for (int i = 0; i < 20; i++) begin
      step("sat", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00,
           (i < 15) ? 4'(i) : 4'd15);
    end
    idle_inputs();
    run_step("sat_hold", 2'b00, 2'b00, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
